// File: rtl/gate_response_checker.sv
// Sweeps the four {a,b} vectors through the 2-input gate block and checks all seven outputs against the truth table.
// A sweep takes 4*(SETTLE_CYCLES+2) busy cycles plus one DONE cycle; start outside IDLE is dropped.
module gate_response_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             drv_a,
  output logic             drv_b,
  input  logic             out_and,
  input  logic             out_or,
  input  logic             out_not,
  input  logic             out_nand,
  input  logic             out_nor,
  input  logic             out_xor,
  input  logic             out_xnor,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       fail_vec,
  output logic [6:0]       fail_mask
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  state_e           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [1:0]       drv_q, drv_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [1:0]       fail_vec_q, fail_vec_d;
  logic [6:0]       fail_mask_q, fail_mask_d;
  logic             pass_q, pass_d;
  logic [6:0]       exp_res, obs_res, mismatch;

  // Bit order {xnor,xor,nor,nand,not,or,and}, matching fail_mask.
  always_comb begin
    exp_res  = {~(drv_q[1] ^ drv_q[0]), drv_q[1] ^ drv_q[0], ~(drv_q[1] | drv_q[0]),
                ~(drv_q[1] & drv_q[0]), ~drv_q[1], drv_q[1] | drv_q[0], drv_q[1] & drv_q[0]};
    obs_res  = {out_xnor, out_xor, out_nor, out_nand, out_not, out_or, out_and};
    mismatch = obs_res ^ exp_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_DRIVE;
      S_DRIVE:  state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == 4'd0) state_d = S_CHECK;
      S_CHECK:  state_d = (vec_q == 2'd3) ? S_DONE : S_DRIVE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
    done = (state_q == S_DONE);
  end

  always_comb begin
    vec_d       = vec_q;
    drv_d       = drv_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    fail_vec_d  = fail_vec_q;
    fail_mask_d = fail_mask_q;
    pass_d      = pass_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_d       = 2'd0;
          drv_d       = 2'd0;
          err_d       = '0;
          fail_vec_d  = 2'd0;
          fail_mask_d = 7'd0;
          pass_d      = 1'b0;
        end
      end
      S_DRIVE:  cnt_d = SETTLE_LOAD;
      S_SETTLE: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      S_CHECK: begin
        if (mismatch != 7'd0) begin
          if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          // A saturated counter never returns to zero, so zero still means "no failure yet".
          if (err_q == '0) begin
            fail_vec_d  = vec_q;
            fail_mask_d = mismatch;
          end
        end
        if (vec_q == 2'd3) begin
          pass_d = (err_d == '0);
        end else begin
          vec_d = vec_q + 2'd1;
          drv_d = vec_q + 2'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q       <= 2'd0;
      drv_q       <= 2'd0;
      cnt_q       <= 4'd0;
      err_q       <= '0;
      fail_vec_q  <= 2'd0;
      fail_mask_q <= 7'd0;
      pass_q      <= 1'b0;
    end else begin
      vec_q       <= vec_d;
      drv_q       <= drv_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      fail_vec_q  <= fail_vec_d;
      fail_mask_q <= fail_mask_d;
      pass_q      <= pass_d;
    end
  end

  assign drv_a     = drv_q[1];
  assign drv_b     = drv_q[0];
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_vec_q;
  assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Drives two checkers (ERR_W=4 and ERR_W=1) from a faultable gate model and scores them against a sweep-level model.
module tb_gate_response_checker;

  localparam int S   = 2;
  localparam int PER = S + 2;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  always #5 clk = ~clk;

  // Truth table per {a,b}, bit order {xnor,xor,nor,nand,not,or,and}.
  logic [6:0] tt   [4];
  logic [6:0] flip [4];
  logic [6:0] g_m, g_s;

  logic       m_a, m_b, m_busy, m_done, m_pass;
  logic [3:0] m_err;
  logic [1:0] m_fvec;
  logic [6:0] m_fmask;
  logic       s_a, s_b, s_busy, s_done, s_pass;
  logic [0:0] s_err;
  logic [1:0] s_fvec;
  logic [6:0] s_fmask;

  always_comb begin
    g_m = tt[{m_a, m_b}] ^ flip[{m_a, m_b}];
    g_s = tt[{s_a, s_b}] ^ flip[{s_a, s_b}];
  end

  gate_response_checker #(.SETTLE_CYCLES(S), .ERR_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .drv_a(m_a), .drv_b(m_b),
    .out_and(g_m[0]), .out_or(g_m[1]), .out_not(g_m[2]), .out_nand(g_m[3]),
    .out_nor(g_m[4]), .out_xor(g_m[5]), .out_xnor(g_m[6]),
    .busy(m_busy), .done(m_done), .pass(m_pass), .err_count(m_err),
    .fail_vec(m_fvec), .fail_mask(m_fmask)
  );

  gate_response_checker #(.SETTLE_CYCLES(S), .ERR_W(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .drv_a(s_a), .drv_b(s_b),
    .out_and(g_s[0]), .out_or(g_s[1]), .out_not(g_s[2]), .out_nand(g_s[3]),
    .out_nor(g_s[4]), .out_xor(g_s[5]), .out_xnor(g_s[6]),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
    .fail_vec(s_fvec), .fail_mask(s_fmask)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_main_zero"}, 32'({m_a, m_b, m_busy, m_done, m_pass, m_err, m_fvec, m_fmask}), 32'd0);
    chk({tag, "_sat_zero"},  32'({s_a, s_b, s_busy, s_done, s_pass, s_err, s_fvec, s_fmask}), 32'd0);
  endtask

  // Expected results of a whole sweep, derived only from the per-vector fault table.
  int         e_cnt;
  logic [1:0] e_fvec;
  logic [6:0] e_fmask;

  task automatic model_sweep();
    int first;
    first = -1;
    e_cnt = 0;
    for (int v = 0; v < 4; v++) begin
      if (flip[v] != 7'd0) begin
        e_cnt++;
        if (first < 0) first = v;
      end
    end
    e_fvec  = (first < 0) ? 2'd0 : 2'(first);
    e_fmask = (first < 0) ? 7'd0 : flip[first];
  endtask

  task automatic chk_results(input string tag);
    chk({tag, "_err"},       32'(m_err),   32'((e_cnt > 15) ? 15 : e_cnt));
    chk({tag, "_fvec"},      32'(m_fvec),  32'(e_fvec));
    chk({tag, "_fmask"},     32'(m_fmask), 32'(e_fmask));
    chk({tag, "_pass"},      32'(m_pass),  32'(e_cnt == 0));
    chk({tag, "_sat_err"},   32'(s_err),   32'(e_cnt > 0));
    chk({tag, "_sat_fvec"},  32'(s_fvec),  32'(e_fvec));
    chk({tag, "_sat_fmask"}, 32'(s_fmask), 32'(e_fmask));
    chk({tag, "_sat_pass"},  32'(s_pass),  32'(e_cnt == 0));
  endtask

  // extra_k: cycle index at which a stray start is raised (-1 none); rst_k: cycle at which reset hits (-1 none).
  task automatic run_sweep(input string tag, input logic [6:0] f0, input logic [6:0] f1,
                           input logic [6:0] f2, input logic [6:0] f3,
                           input int extra_k, input int rst_k);
    int cum;
    @(negedge clk);
    flip[0] = f0; flip[1] = f1; flip[2] = f2; flip[3] = f3;
    model_sweep();
    start = 1'b1;
    cum = 0;
    for (int k = 0; k <= 4 * PER; k++) begin
      @(negedge clk);
      if (k == rst_k) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero({tag, "_rst"});
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk_zero({tag, "_post_rst"});
        end
        return;
      end
      if (k < 4 * PER) begin
        chk({tag, "_busy"}, 32'({m_busy, m_done, s_busy, s_done}), 32'b1010);
        chk({tag, "_drv"},  32'({m_a, m_b}), 32'(k / PER));
        chk({tag, "_sdrv"}, 32'({s_a, s_b}), 32'(k / PER));
        if (k == 0)
          chk({tag, "_clr"}, 32'({m_pass, m_err, m_fvec, m_fmask, s_pass, s_err}), 32'd0);
        if (k > 0 && k % PER == 0) begin
          if (flip[k / PER - 1] != 7'd0) cum++;
          chk({tag, "_err_mid"}, 32'(m_err), 32'(cum));
        end
      end else begin
        chk({tag, "_done"}, 32'({m_busy, m_done, s_busy, s_done}), 32'b0101);
        chk_results({tag, "_fin"});
      end
      start = (k == extra_k);
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_idle"}, 32'({m_busy, m_done, s_busy, s_done, m_a, m_b}), 32'b000011);
    chk_results({tag, "_hold"});
    @(negedge clk);
    chk({tag, "_idle2"}, 32'({m_busy, m_done, s_busy, s_done}), 32'd0);
  endtask

  initial begin
    tt[0] = 7'h5C; tt[1] = 7'h2E; tt[2] = 7'h2A; tt[3] = 7'h43;
    for (int v = 0; v < 4; v++) flip[v] = 7'd0;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_zero("no_start");
    end

    run_sweep("clean",      7'h00, 7'h00, 7'h00, 7'h00, -1, -1);
    run_sweep("xor_stuck0", 7'h00, 7'h20, 7'h20, 7'h00, -1, -1);
    run_sweep("all_inv",    7'h7F, 7'h7F, 7'h7F, 7'h7F, -1, -1);
    run_sweep("start_settle", 7'h00, 7'h00, 7'h00, 7'h00, 2 * PER + 1, -1);
    run_sweep("start_done", 7'h00, 7'h08, 7'h00, 7'h00, 4 * PER, -1);
    run_sweep("rst_check1", 7'h01, 7'h00, 7'h00, 7'h00, -1, PER + PER - 1);
    run_sweep("fresh",      7'h00, 7'h00, 7'h00, 7'h00, -1, -1);

    for (int n = 0; n < 24; n++) begin
      logic [6:0] f [4];
      int xk;
      for (int v = 0; v < 4; v++)
        f[v] = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(1, 127)) : 7'd0;
      xk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4 * PER)) : -1;
      run_sweep("rand", f[0], f[1], f[2], f[3], xk, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
